// File: rtl/first_nios2_system_sysid_pkg.sv
// Shared constants and FSM state type for the system-ID checker.
package first_nios2_system_sysid_pkg;

    localparam logic        SYSID_ADDR_ID    = 1'b0;
    localparam logic        SYSID_ADDR_TS    = 1'b1;

    localparam logic [31:0] SYSID_DEFAULT_ID = 32'd0;
    localparam logic [31:0] SYSID_DEFAULT_TS = 32'd1362613388;

    typedef enum logic [4:0] {
        ST_IDLE  = 5'b00001,
        ST_RD_ID = 5'b00010,
        ST_RD_TS = 5'b00100,
        ST_CHECK = 5'b01000,
        ST_DONE  = 5'b10000
    } sysid_state_e;

endpackage

// File: rtl/first_nios2_system_sysid_checker_tmo.sv
// Saturating 16-bit stall counter; flags the stall cycle that would reach LIMIT.
module first_nios2_system_sysid_checker_tmo #(
    parameter logic [15:0] LIMIT = 16'd255
) (
    input  logic clock,
    input  logic reset_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_limit_hit
);

    localparam logic [15:0] LP_LAST = LIMIT - 16'd1;

    logic [15:0] r_count;

    // NOTE: sequential state uses non-blocking assignment so every register
    // updates from pre-edge values, independent of statement order.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_count <= 16'd0;
        end else if (i_clear) begin
            r_count <= 16'd0;
        end else if (i_enable && (r_count != 16'hFFFF)) begin
            r_count <= r_count + 16'd1;
        end
    end

    // The current stall cycle is the LIMIT-th one when LIMIT-1 have already been counted.
    assign o_limit_hit = i_enable && (r_count >= LP_LAST);

endmodule

// File: rtl/first_nios2_system_sysid_checker.sv
// Avalon-MM master that reads the sysid slave (ID then timestamp) and reports pass/fail.
module first_nios2_system_sysid_checker
    import first_nios2_system_sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = SYSID_DEFAULT_ID,
    parameter logic [31:0] EXPECTED_TS    = SYSID_DEFAULT_TS,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_mismatch,
    output logic        ts_mismatch,
    output logic        timeout,
    output logic [31:0] captured_id,
    output logic [31:0] captured_ts
);

    localparam logic [15:0] LP_LIMIT = 16'(TIMEOUT_CYCLES);

    sysid_state_e r_state;
    sysid_state_e w_state_nxt;

    logic        r_pending;
    logic        r_read;
    logic        r_address;
    logic        r_busy;
    logic        r_done;
    logic        r_pass;
    logic        r_id_mismatch;
    logic        r_ts_mismatch;
    logic        r_timeout;
    logic [31:0] r_captured_id;
    logic [31:0] r_captured_ts;

    logic w_start_check;
    logic w_issue;
    logic w_cap_id;
    logic w_cap_ts;
    logic w_tmo;
    logic w_check;
    logic w_stall;
    logic w_limit_hit;

    assign w_stall = r_read && avm_waitrequest;

    first_nios2_system_sysid_checker_tmo #(
        .LIMIT (LP_LIMIT)
    ) u_tmo (
        .clock       (clock),
        .reset_n     (reset_n),
        .i_clear     (w_start_check | w_cap_id | w_cap_ts),
        .i_enable    (w_stall),
        .o_limit_hit (w_limit_hit)
    );

    // NOTE: every combinational output gets a default first so no path
    // through the case leaves a signal unassigned and infers a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_start_check = 1'b0;
        w_issue       = 1'b0;
        w_cap_id      = 1'b0;
        w_cap_ts      = 1'b0;
        w_tmo         = 1'b0;
        w_check       = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (r_pending || start) begin
                    w_start_check = 1'b1;
                    w_state_nxt   = ST_RD_ID;
                end
            end
            ST_RD_ID: begin
                // First cycle in RD_ID only registers the request.
                if (!r_read) begin
                    w_issue = 1'b1;
                end else if (!avm_waitrequest) begin
                    w_cap_id    = 1'b1;
                    w_state_nxt = ST_RD_TS;
                end else if (w_limit_hit) begin
                    w_tmo       = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_RD_TS: begin
                if (!avm_waitrequest) begin
                    w_cap_ts    = 1'b1;
                    w_state_nxt = ST_CHECK;
                end else if (w_limit_hit) begin
                    w_tmo       = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_CHECK: begin
                w_check     = 1'b1;
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (start) begin
                    w_start_check = 1'b1;
                    w_state_nxt   = ST_RD_ID;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_pending     <= 1'b1;
            r_read        <= 1'b0;
            r_address     <= SYSID_ADDR_ID;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_id_mismatch <= 1'b0;
            r_ts_mismatch <= 1'b0;
            r_timeout     <= 1'b0;
            r_captured_id <= 32'd0;
            r_captured_ts <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start_check) begin
                r_pending     <= 1'b0;
                r_busy        <= 1'b1;
                r_done        <= 1'b0;
                r_pass        <= 1'b0;
                r_id_mismatch <= 1'b0;
                r_ts_mismatch <= 1'b0;
                r_timeout     <= 1'b0;
                r_read        <= 1'b0;
                r_address     <= SYSID_ADDR_ID;
            end
            if (w_issue) begin
                r_read    <= 1'b1;
                r_address <= SYSID_ADDR_ID;
            end
            if (w_cap_id) begin
                r_captured_id <= avm_readdata;
                r_address     <= SYSID_ADDR_TS;
            end
            if (w_cap_ts) begin
                r_captured_ts <= avm_readdata;
                r_read        <= 1'b0;
            end
            if (w_tmo) begin
                r_read        <= 1'b0;
                r_timeout     <= 1'b1;
                r_id_mismatch <= 1'b0;
                r_ts_mismatch <= 1'b0;
                r_pass        <= 1'b0;
                r_busy        <= 1'b0;
                r_done        <= 1'b1;
            end
            if (w_check) begin
                r_id_mismatch <= (r_captured_id != EXPECTED_ID);
                r_ts_mismatch <= (r_captured_ts != EXPECTED_TS);
                r_pass        <= (r_captured_id == EXPECTED_ID) && (r_captured_ts == EXPECTED_TS);
                r_busy        <= 1'b0;
                r_done        <= 1'b1;
            end
        end
    end

    assign avm_address = r_address;
    assign avm_read    = r_read;
    assign busy        = r_busy;
    assign done        = r_done;
    assign pass        = r_pass;
    assign id_mismatch = r_id_mismatch;
    assign ts_mismatch = r_ts_mismatch;
    assign timeout     = r_timeout;
    assign captured_id = r_captured_id;
    assign captured_ts = r_captured_ts;

endmodule

// File: tb/tb_first_nios2_system_sysid_checker.sv
// Directed bench: zero-wait run, ID mismatch, timeout, TS stall with ignored start, reset mid-read.
module tb_first_nios2_system_sysid_checker;

    localparam logic [31:0] TS_OK = 32'd1362613388;  // 32'h5137D48C

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic        avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;
    logic        busy, done, pass, id_mismatch, ts_mismatch, timeout;
    logic [31:0] captured_id, captured_ts;

    // Responder controls
    logic [31:0] id_val     = 32'd0;
    logic        force_stall = 1'b0;
    int          ts_stalls  = 0;
    int          ts_cnt     = 0;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    assign avm_readdata    = avm_address ? TS_OK : id_val;
    assign avm_waitrequest = force_stall | (avm_read && avm_address && (ts_cnt < ts_stalls));

    always @(posedge clock) begin
        if (!(avm_read && avm_address)) ts_cnt <= 0;
        else if (avm_waitrequest)       ts_cnt <= ts_cnt + 1;
    end

    first_nios2_system_sysid_checker #(
        .EXPECTED_ID    (32'd0),
        .EXPECTED_TS    (TS_OK),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .start           (start),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .id_mismatch     (id_mismatch),
        .ts_mismatch     (ts_mismatch),
        .timeout         (timeout),
        .captured_id     (captured_id),
        .captured_ts     (captured_ts)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        step(3);
        check("rst_read", avm_read, 1'b0);
        check("rst_addr", avm_address, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_pass", pass, 1'b0);
        check("rst_tmo", timeout, 1'b0);
        check("rst_capid", captured_id, 32'd0);
        check("rst_capts", captured_ts, 32'd0);

        // Auto-check after reset release, zero-wait responder
        reset_n = 1'b1;
        step(1);
        check("auto_busy", busy, 1'b1);
        check("auto_read0", avm_read, 1'b0);
        step(1);
        check("auto_read_id", avm_read, 1'b1);
        check("auto_addr_id", avm_address, 1'b0);
        step(1);
        check("auto_read_ts", avm_read, 1'b1);
        check("auto_addr_ts", avm_address, 1'b1);
        step(1);
        check("auto_read_off", avm_read, 1'b0);
        check("auto_capts", captured_ts, TS_OK);
        check("auto_done_early", done, 1'b0);
        step(1);
        check("auto_done", done, 1'b1);
        check("auto_pass", pass, 1'b1);
        check("auto_busy_off", busy, 1'b0);
        check("auto_idm", id_mismatch, 1'b0);
        check("auto_tsm", ts_mismatch, 1'b0);

        // ID mismatch, started from DONE
        id_val = 32'h00000001;
        pulse_start();
        check("mm_busy", busy, 1'b1);
        check("mm_done_clr", done, 1'b0);
        check("mm_pass_clr", pass, 1'b0);
        step(4);
        check("mm_done", done, 1'b1);
        check("mm_idm", id_mismatch, 1'b1);
        check("mm_tsm", ts_mismatch, 1'b0);
        check("mm_pass", pass, 1'b0);
        check("mm_capid", captured_id, 32'h00000001);

        // Timeout: waitrequest stuck high, limit 4
        force_stall = 1'b1;
        pulse_start();
        check("to_idm_clr", id_mismatch, 1'b0);
        step(1);
        check("to_read_on", avm_read, 1'b1);
        check("to_addr", avm_address, 1'b0);
        step(3);
        check("to_read_4th", avm_read, 1'b1);
        check("to_done_early", done, 1'b0);
        step(1);
        check("to_read_off", avm_read, 1'b0);
        check("to_timeout", timeout, 1'b1);
        check("to_done", done, 1'b1);
        check("to_pass", pass, 1'b0);
        check("to_idm", id_mismatch, 1'b0);
        check("to_tsm", ts_mismatch, 1'b0);
        check("to_busy", busy, 1'b0);
        force_stall = 1'b0;

        // Three stall cycles on timestamp read, plus a start pulse mid-check
        id_val    = 32'd0;
        ts_stalls = 3;
        pulse_start();
        check("st_tmo_clr", timeout, 1'b0);
        step(2);
        check("st_addr_n2", avm_address, 1'b1);
        check("st_capid", captured_id, 32'd0);
        step(1);
        check("st_read_n3", avm_read, 1'b1);
        start = 1'b1;
        step(1);
        start = 1'b0;
        check("st_addr_n4", avm_address, 1'b1);
        check("st_read_n4", avm_read, 1'b1);
        check("st_busy_n4", busy, 1'b1);
        step(1);
        check("st_read_n5", avm_read, 1'b1);
        check("st_done_n5", done, 1'b0);
        step(1);
        check("st_read_n6", avm_read, 1'b0);
        check("st_done_n6", done, 1'b0);
        step(1);
        check("st_done_n7", done, 1'b1);
        check("st_pass", pass, 1'b1);
        step(1);
        check("ign_busy", busy, 1'b0);
        check("ign_done", done, 1'b1);

        // Reset during timestamp stall
        pulse_start();
        step(2);
        check("rr_read_pre", avm_read, 1'b1);
        check("rr_addr_pre", avm_address, 1'b1);
        reset_n   = 1'b0;
        ts_stalls = 0;
        step(1);
        check("rr_read", avm_read, 1'b0);
        check("rr_addr", avm_address, 1'b0);
        check("rr_busy", busy, 1'b0);
        check("rr_done", done, 1'b0);
        check("rr_pass", pass, 1'b0);
        check("rr_capts", captured_ts, 32'd0);
        reset_n = 1'b1;
        step(1);
        check("rr_auto_busy", busy, 1'b1);
        step(4);
        check("rr_auto_done", done, 1'b1);
        check("rr_auto_pass", pass, 1'b1);
        check("rr_auto_capts", captured_ts, TS_OK);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
